// File: rtl/conv_stream_src.sv
`default_nettype none
// ============================================================================
// Module   : conv_stream_src
// Purpose  : Frame-timing stream source for the 3-row convolution line
//            buffer. Forwards upstream pixels one per beat as a raster of
//            V_ACTIVE x H_ACTIVE, pulses rd_hs after each line, then idles
//            for H_BLANK cycles. Line-buffer reads are enabled once
//            PRIME_LINES lines have been written.
// Options  : CONV_SRC_PATTERN_EN - ignore upstream and emit a per-line ramp
//            (1..H_ACTIVE) on every line, never stalling.
// Revision : 1.0 - initial release
// ============================================================================
module conv_stream_src #(
  parameter int DATA_W      = 16,
  parameter int H_ACTIVE    = 418,
  parameter int V_ACTIVE    = 240,
  parameter int H_BLANK     = 4,
  parameter int PRIME_LINES = 2
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_en,
  output logic              rd_hs,
  output logic [15:0]       pix_x,
  output logic [15:0]       pix_y,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACTIVE = 3'd1,
    S_HS     = 3'd2,
    S_HBLANK = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [15:0] X_LAST     = 16'(H_ACTIVE - 1);
  localparam logic [15:0] Y_END      = 16'(V_ACTIVE);
  localparam logic [15:0] PRIME      = 16'(PRIME_LINES);
  localparam logic [15:0] BLANK_LAST = 16'(H_BLANK - 1);

  state_t             state_q, state_d;
  logic [15:0]        x_q, x_d;
  logic [15:0]        y_q, y_d;
  logic [15:0]        blank_q, blank_d;
  logic               wr_en_q, wr_en_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic               rd_en_q, rd_en_d;
  logic               rd_hs_q, rd_hs_d;
  logic [15:0]        pix_x_q, pix_x_d;
  logic [15:0]        pix_y_q, pix_y_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;

  logic               beat_valid;
  logic [DATA_W-1:0]  beat_data;
  logic               accept;

  // Beat source: upstream handshake, or the internal ramp for bring-up
`ifdef CONV_SRC_PATTERN_EN
  logic unused_in;
  assign unused_in  = ^{in_valid, in_data};
  assign beat_valid = 1'b1;
  assign beat_data  = DATA_W'(x_q + 16'd1);
`else
  assign beat_valid = in_valid;
  assign beat_data  = in_data;
`endif

  // Ready depends on state only so upstream sees no valid->ready path
  assign in_ready = (state_q == S_ACTIVE);
  assign accept   = in_ready & beat_valid;

  // Next-state and next-output computation for the line/frame sequencer
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    blank_d      = blank_q;
    wr_en_d      = 1'b0;
    rd_en_d      = 1'b0;
    rd_hs_d      = 1'b0;
    frame_done_d = 1'b0;
    busy_d       = busy_q;
    wr_data_d    = wr_data_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACTIVE;
          x_d     = 16'd0;
          y_d     = 16'd0;
          busy_d  = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_data_d = beat_data;
          pix_x_d   = x_q;
          pix_y_d   = y_q;
          rd_en_d   = (y_q >= PRIME);
          if (x_q == X_LAST) begin
            x_d     = 16'd0;
            state_d = S_HS;
          end else begin
            x_d = x_q + 16'd1;
          end
        end
      end
      S_HS: begin
        rd_hs_d = 1'b1;
        y_d     = y_q + 16'd1;
        blank_d = 16'd0;
        state_d = S_HBLANK;
      end
      S_HBLANK: begin
        // y already counts completed lines here, so y == V_ACTIVE ends the frame
        if (blank_q == BLANK_LAST) begin
          blank_d = 16'd0;
          state_d = (y_q == Y_END) ? S_DONE : S_ACTIVE;
        end else begin
          blank_d = blank_q + 16'd1;
        end
      end
      S_DONE: begin
        frame_done_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any frame in flight
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      blank_q      <= '0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      rd_en_q      <= 1'b0;
      rd_hs_q      <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      blank_q      <= blank_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      rd_en_q      <= rd_en_d;
      rd_hs_q      <= rd_hs_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_data    = wr_data_q;
  assign rd_en      = rd_en_q;
  assign rd_hs      = rd_hs_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire
